// File: rtl/sad_min_tree.sv
// sad_min_tree: registered binary min tree over LANES SAD/index pairs per beat, plus a
// running block minimum with a valid/ready result. Macro SAD_TIE_LOW_LANE_EN: in-tree ties keep the lower lane.

module sad_min_node #(
    parameter int SAD_W = 32,
    parameter int IDX_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SAD_W+IDX_W-1:0] a,
    input  logic [SAD_W+IDX_W-1:0] b,
    output logic [SAD_W+IDX_W-1:0] q
);
    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [IDX_W-1:0] idx;
    } cand_t;

    cand_t ca, cb;
    logic  pick_a;

    assign ca = a;
    assign cb = b;
`ifdef SAD_TIE_LOW_LANE_EN
    assign pick_a = (ca.sad <= cb.sad);
`else
    assign pick_a = (ca.sad < cb.sad);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= pick_a ? a : b;
    end
endmodule

module sad_min_tree #(
    parameter int LANES = 16,
    parameter int SAD_W = 32,
    parameter int IDX_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [LANES*SAD_W-1:0] sad_in,
    input  logic [LANES*IDX_W-1:0] idx_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SAD_W-1:0]       sad_out,
    output logic [IDX_W-1:0]       idx_out,
    output logic [15:0]            beat_cnt
);
    localparam int STAGES = $clog2(LANES);

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [IDX_W-1:0] idx;
    } cand_t;

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t            state, state_nxt;
    logic              started, accept;
    logic [STAGES:0]   vld_pipe, last_pipe;
    logic [STAGES-1:0] vld_q, last_q;
    cand_t             node [1:2*LANES-1];
    cand_t             acc, acc_nxt;
    logic              acc_full, tree_win, tree_vld, tree_last;
    logic [15:0]       acc_cnt, cnt_nxt;

    // Heap-ordered tree: leaves at LANES+k, node i = min(2i, 2i+1), root at 1.
    // The even child always carries the lower lanes.
    for (genvar k = 0; k < LANES; k++) begin : g_leaf
        assign node[LANES+k] = {sad_in[k*SAD_W +: SAD_W], idx_in[k*IDX_W +: IDX_W]};
    end

    for (genvar i = 1; i < LANES; i++) begin : g_node
        sad_min_node #(.SAD_W(SAD_W), .IDX_W(IDX_W)) u_node (
            .clk   (clk),
            .rst_n (rst_n),
            .a     (node[2*i]),
            .b     (node[2*i+1]),
            .q     (node[i])
        );
    end

    assign accept    = in_valid && in_ready;
    assign vld_pipe  = {vld_q, accept};
    assign last_pipe = {last_q, accept && in_last};
    assign tree_vld  = vld_pipe[STAGES];
    assign tree_last = last_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= vld_pipe[STAGES-1:0];
            last_q <= last_pipe[STAGES-1:0];
        end
    end

    // Strict compare across beats so the earliest beat keeps a tie.
    assign tree_win = !acc_full || (node[1].sad < acc.sad);
    assign acc_nxt  = tree_win ? node[1] : acc;
    assign cnt_nxt  = !acc_full ? 16'd1 : ((&acc_cnt) ? acc_cnt : acc_cnt + 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_full <= 1'b0;
            acc      <= '0;
            acc_cnt  <= '0;
        end else if (tree_vld) begin
            acc_full <= 1'b1;
            acc      <= acc_nxt;
            acc_cnt  <= cnt_nxt;
        end else if (out_valid && out_ready) begin
            acc_full <= 1'b0;
            acc_cnt  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sad_out  <= '0;
            idx_out  <= '0;
            beat_cnt <= '0;
        end else if (tree_vld && tree_last) begin
            sad_out  <= acc_nxt.sad;
            idx_out  <= acc_nxt.idx;
            beat_cnt <= cnt_nxt;
        end
    end

    // started keeps in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && in_last)      state_nxt = DRAIN;
            DRAIN:   if (tree_vld && tree_last)  state_nxt = HOLD;
            HOLD:    if (out_ready)              state_nxt = ACCUM;
            default:                             state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM) && started;
        out_valid = (state == HOLD);
    end
endmodule
